// File: rtl/vram_arbiter.sv
// Single-port framebuffer RAM arbiter: display reads always win, queued writes
// from a small FIFO drain into every slot the display leaves idle.
module vram_arbiter #(
  parameter  int ADDR_W     = 16,
  parameter  int DATA_W     = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int LVL_W      = PTR_W + 1
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              disp_req_i,
  input  logic [ADDR_W-1:0] disp_addr_i,
  output logic [DATA_W-1:0] disp_data_o,
  output logic              disp_valid_o,
  input  logic              wr_valid_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              wr_ready_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic [LVL_W-1:0]  fifo_level_o,
  output logic              err_sticky_o
);

  typedef enum logic [1:0] {SLOT_IDLE, SLOT_READ, SLOT_WRITE} slot_e;

  slot_e slot;

  logic [ADDR_W+DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]         level_q, level_d;
  logic                     push, pop;
  logic [ADDR_W-1:0]        head_addr;
  logic [DATA_W-1:0]        head_data;

  logic [ADDR_W-1:0]        ram_addr_q, ram_addr_d;
  logic                     ram_we_q, ram_we_d;
  logic [DATA_W-1:0]        ram_wdata_q, ram_wdata_d;

  logic [1:0]               rd_pipe_q, rd_pipe_d;
  logic                     disp_valid_q, disp_valid_d;
  logic [DATA_W-1:0]        disp_data_q, disp_data_d;
  logic                     req_prev_q, req_prev_d;
  logic                     err_q, err_d;

  // Ready depends only on the registered count, so a full FIFO never accepts even if popping.
  assign wr_ready_o = (level_q < LVL_W'(FIFO_DEPTH));
  assign push       = wr_valid_i & wr_ready_o;
  assign {head_addr, head_data} = fifo_mem[rd_ptr_q];

  always_comb begin
    slot = SLOT_IDLE;
    if (disp_req_i)
      slot = SLOT_READ;
    else if (level_q != '0)
      slot = SLOT_WRITE;
  end

  assign pop = (slot == SLOT_WRITE);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q + LVL_W'(push) - LVL_W'(pop);
  end

  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = 1'b0;
    case (slot)
      SLOT_READ: ram_addr_d = disp_addr_i;
      SLOT_WRITE: begin
        ram_addr_d  = head_addr;
        ram_wdata_d = head_data;
        ram_we_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // Two-stage marker tracks a read from command to returned RAM data.
  always_comb begin
    rd_pipe_d    = {rd_pipe_q[0], disp_req_i};
    disp_valid_d = rd_pipe_q[1];
    disp_data_d  = rd_pipe_q[1] ? ram_rdata_i : disp_data_q;
    req_prev_d   = disp_req_i;
    err_d        = err_q | (disp_req_i & req_prev_q);
  end

  always_ff @(posedge clk_i) begin
    if (push)
      fifo_mem[wr_ptr_q] <= {wr_addr_i, wr_data_i};
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= '0;
      rd_pipe_q    <= '0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
      req_prev_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      ram_addr_q   <= ram_addr_d;
      ram_we_q     <= ram_we_d;
      ram_wdata_q  <= ram_wdata_d;
      rd_pipe_q    <= rd_pipe_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
      req_prev_q   <= req_prev_d;
      err_q        <= err_d;
    end
  end

  assign ram_addr_o   = ram_addr_q;
  assign ram_we_o     = ram_we_q;
  assign ram_wdata_o  = ram_wdata_q;
  assign disp_valid_o = disp_valid_q;
  assign disp_data_o  = disp_data_q;
  assign fifo_level_o = level_q;
  assign err_sticky_o = err_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: a behavioural RAM plus a transaction-level model
// (write queue, memory image, scheduled read returns) checked every cycle.
module tb_vram_arbiter;
  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LW    = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [LW-1:0] fifo_level;
  logic          err_sticky;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .disp_req_i(disp_req), .disp_addr_i(disp_addr),
    .disp_data_o(disp_data), .disp_valid_o(disp_valid),
    .wr_valid_i(wr_valid), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_ready_o(wr_ready),
    .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata),
    .fifo_level_o(fifo_level), .err_sticky_o(err_sticky)
  );

  // Behavioural single-port synchronous RAM
  logic [DW-1:0] ram_mem [65536];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    ram_rdata <= ram_mem[ram_addr];
  end

  // Reference model state
  logic [AW+DW-1:0] m_fifo [$];
  logic [DW-1:0]    ref_mem [65536];
  logic [DW-1:0]    exp_rd [int];
  logic             m_we;
  logic [AW-1:0]    m_addr;
  logic [DW-1:0]    m_wdata;
  logic [DW-1:0]    m_last;
  logic             m_prev;
  logic             m_err;
  int               cyc = 0;

  task automatic model_reset();
    m_fifo.delete();
    exp_rd.delete();
    m_we = 0; m_addr = '0; m_wdata = '0; m_last = '0; m_prev = 0; m_err = 0;
  endtask

  // Drive one cycle, advance the model by the transaction rules, check the result.
  task automatic step(input logic r, input logic [AW-1:0] ra,
                      input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    int  sz;
    logic [AW+DW-1:0] e;
    disp_req = r; disp_addr = ra; wr_valid = wv; wr_addr = wa; wr_data = wd;
    sz = m_fifo.size();
    checks++;
    if (wr_ready !== (sz < DEPTH)) begin
      errors++; $display("FAIL wr_ready cyc=%0d got=%b exp=%b", cyc, wr_ready, sz < DEPTH);
    end
    checks++;
    if (fifo_level !== LW'(sz)) begin
      errors++; $display("FAIL fifo_level cyc=%0d got=%0d exp=%0d", cyc, fifo_level, sz);
    end
    // the write command visible this cycle lands in RAM at the coming edge
    if (m_we) ref_mem[m_addr] = m_wdata;
    if (r) begin
      exp_rd[cyc + 3] = ref_mem[ra];
      m_addr = ra; m_we = 0;
    end else if (sz > 0) begin
      e = m_fifo.pop_front();
      m_we = 1; m_addr = e[AW+DW-1:DW]; m_wdata = e[DW-1:0];
    end else begin
      m_we = 0;
    end
    if (wv && sz < DEPTH) m_fifo.push_back({wa, wd});
    if (r && m_prev) m_err = 1;
    m_prev = r;
    @(posedge clk); #1;
    cyc++;
    checks++;
    if (ram_we !== m_we) begin
      errors++; $display("FAIL ram_we cyc=%0d got=%b exp=%b", cyc, ram_we, m_we);
    end
    checks++;
    if (ram_addr !== m_addr) begin
      errors++; $display("FAIL ram_addr cyc=%0d got=%h exp=%h", cyc, ram_addr, m_addr);
    end
    if (m_we) begin
      checks++;
      if (ram_wdata !== m_wdata) begin
        errors++; $display("FAIL ram_wdata cyc=%0d got=%h exp=%h", cyc, ram_wdata, m_wdata);
      end
    end
    checks++;
    if (disp_valid !== exp_rd.exists(cyc)) begin
      errors++; $display("FAIL disp_valid cyc=%0d got=%b exp=%b", cyc, disp_valid, exp_rd.exists(cyc));
    end
    if (exp_rd.exists(cyc)) begin
      m_last = exp_rd[cyc];
      exp_rd.delete(cyc);
    end
    checks++;
    if (disp_data !== m_last) begin
      errors++; $display("FAIL disp_data cyc=%0d got=%h exp=%h", cyc, disp_data, m_last);
    end
    checks++;
    if (err_sticky !== m_err) begin
      errors++; $display("FAIL err_sticky cyc=%0d got=%b exp=%b", cyc, err_sticky, m_err);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, '0);
  endtask

  task automatic test_reset();
    $display("test_reset");
    reset_n = 0;
    for (int i = 0; i < 5; i++) begin
      disp_req = 1'($urandom); disp_addr = AW'($urandom);
      wr_valid = 1'($urandom); wr_addr = AW'($urandom); wr_data = DW'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({ram_addr, ram_we, ram_wdata, disp_data, disp_valid, fifo_level, err_sticky} !== '0) begin
        errors++;
        $display("FAIL reset_outputs got addr=%h we=%b wd=%h dd=%h dv=%b lvl=%0d err=%b exp all zero",
                 ram_addr, ram_we, ram_wdata, disp_data, disp_valid, fifo_level, err_sticky);
      end
    end
    disp_req = 0; wr_valid = 0;
    reset_n = 1;
    model_reset();
    #1;
    checks++;
    if (wr_ready !== 1'b1 || fifo_level !== '0) begin
      errors++; $display("FAIL reset_release got ready=%b lvl=%0d exp ready=1 lvl=0", wr_ready, fifo_level);
    end
  endtask

  task automatic test_single_write_read();
    $display("test_single_write_read");
    idle(2);
    step(0, '0, 1, 16'h0010, 8'hA5);
    step(0, '0, 0, '0, '0);
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 16'h0010 || ram_wdata !== 8'hA5) begin
      errors++; $display("FAIL write_latency got we=%b addr=%h data=%h exp we=1 addr=0010 data=a5",
                         ram_we, ram_addr, ram_wdata);
    end
    idle(2);
    step(1, 16'h0010, 0, '0, '0);
    idle(2);
    checks++;
    if (disp_valid !== 1'b1 || disp_data !== 8'hA5) begin
      errors++; $display("FAIL read_latency got valid=%b data=%h exp valid=1 data=a5", disp_valid, disp_data);
    end
    idle(1);
  endtask

  task automatic test_random();
    logic r, prev;
    $display("test_random");
    prev = 0;
    for (int i = 0; i < 300; i++) begin
      r = !prev && ($urandom_range(0, 1) == 1);
      step(r, AW'($urandom_range(0, 63)), ($urandom_range(0, 3) != 0),
           AW'($urandom_range(0, 63)), DW'($urandom));
      prev = r;
    end
    idle(8);
  endtask

  task automatic test_active_video();
    int  max_lvl;
    bit  saw_full;
    $display("test_active_video");
    max_lvl = 0; saw_full = 0;
    for (int i = 0; i < 24; i++) begin
      step((i % 2) == 0, AW'(16'h0200 + i), 1, AW'(16'h0100 + i), DW'($urandom));
      if (int'(fifo_level) > max_lvl) max_lvl = int'(fifo_level);
      if (wr_ready === 1'b0) saw_full = 1;
    end
    checks++;
    if (max_lvl != DEPTH || !saw_full) begin
      errors++; $display("FAIL active_fill got max_level=%0d saw_not_ready=%0d exp 4 and 1", max_lvl, saw_full);
    end
  endtask

  task automatic test_full_boundary();
    logic r;
    $display("test_full_boundary");
    r = 0;
    for (int i = 0; i < 20 && fifo_level != LW'(DEPTH); i++) begin
      r = !r;
      step(r, AW'(16'h0300 + i), 1, AW'(16'h0180 + i), DW'($urandom));
    end
    checks++;
    if (fifo_level !== LW'(DEPTH)) begin
      errors++; $display("FAIL fill_to_full got level=%0d exp 4 within budget", fifo_level);
    end
    step(0, '0, 1, 16'h01F0, 8'h3C);
    checks++;
    if (fifo_level !== 3'd3 || wr_ready !== 1'b1) begin
      errors++; $display("FAIL full_pop got level=%0d ready=%b exp 3 and 1", fifo_level, wr_ready);
    end
    step(0, '0, 1, 16'h01F1, 8'h3D);
    checks++;
    if (fifo_level !== 3'd3) begin
      errors++; $display("FAIL push_pop_same got level=%0d exp 3", fifo_level);
    end
    idle(6);
  endtask

  task automatic test_violation();
    $display("test_violation");
    idle(2);
    step(1, 16'h0010, 0, '0, '0);
    step(1, 16'h0011, 0, '0, '0);
    checks++;
    if (err_sticky !== 1'b1) begin
      errors++; $display("FAIL err_set got=%b exp=1", err_sticky);
    end
    step(0, '0, 0, '0, '0);
    checks++;
    if (disp_valid !== 1'b1) begin
      errors++; $display("FAIL viol_first_valid got=%b exp=1", disp_valid);
    end
    step(0, '0, 0, '0, '0);
    checks++;
    if (disp_valid !== 1'b1) begin
      errors++; $display("FAIL viol_second_valid got=%b exp=1", disp_valid);
    end
    idle(5);
    checks++;
    if (err_sticky !== 1'b1) begin
      errors++; $display("FAIL err_hold got=%b exp=1", err_sticky);
    end
  endtask

  task automatic test_reset_midop();
    logic r;
    $display("test_reset_midop");
    r = 0;
    for (int i = 0; i < 20 && fifo_level < 3'd3; i++) begin
      r = !r;
      step(r, AW'(16'h0020 + i), 1, AW'(16'h0400 + i), DW'($urandom));
    end
    step(0, '0, 1, 16'h0410, 8'h77);
    step(1, 16'h0020, 0, '0, '0);
    checks++;
    if (fifo_level !== 3'd3) begin
      errors++; $display("FAIL midop_setup got level=%0d exp 3", fifo_level);
    end
    reset_n = 0;
    #1;
    checks++;
    if (ram_we !== 1'b0 || disp_valid !== 1'b0 || fifo_level !== '0 || err_sticky !== 1'b0) begin
      errors++; $display("FAIL midop_async got we=%b dv=%b lvl=%0d err=%b exp all zero",
                         ram_we, disp_valid, fifo_level, err_sticky);
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      step(0, '0, 0, '0, '0);
      checks++;
      if (ram_we !== 1'b0 || disp_valid !== 1'b0 || fifo_level !== '0) begin
        errors++; $display("FAIL midop_quiet cyc=%0d got we=%b dv=%b lvl=%0d exp 0 0 0",
                           cyc, ram_we, disp_valid, fifo_level);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram_mem[i] = '0;
      ref_mem[i] = '0;
    end
    model_reset();
    test_reset();
    test_single_write_read();
    test_random();
    test_active_video();
    test_full_boundary();
    test_violation();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
